pc_sequencer: RTL and testbench

Program-counter and phase sequencer for the multi-cycle DLX core. It sits directly upstream of the instruction decoder. It holds the PC, drives the instruction-memory address, and steps the one-hot phase strobes IF→ID→EX→MEM→WB that pace the decoder and later stages. It consumes the decoder's `Pc_cmd`/`Pc_val`/`Iv` outputs to select the next PC at the end of each instruction.

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decoder-facing bundle for the PC/phase sequencer: decoder controls in, fetch address and phase strobes out.
interface pc_sequencer_if;
  logic        run;
  logic        stall;
  logic [1:0]  Pc_cmd;
  logic [1:0]  Pc_val;
  logic [31:0] Iv;
  logic [31:0] rs1_data;
  logic        alu_cond;
  logic [31:0] i_address;
  logic [31:0] pc_plus4;
  logic        IF;
  logic        ID;
  logic        EX;
  logic        MEM;
  logic        WB;

  modport master (
    input  run, stall, Pc_cmd, Pc_val, Iv, rs1_data, alu_cond,
    output i_address, pc_plus4, IF, ID, EX, MEM, WB
  );

  modport slave (
    output run, stall, Pc_cmd, Pc_val, Iv, rs1_data, alu_cond,
    input  i_address, pc_plus4, IF, ID, EX, MEM, WB
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and IF/ID/EX/MEM/WB phase sequencer for the multi-cycle DLX core.
//
// state | meaning
// S_IF  | fetch address presented; wait for run
// S_ID  | instruction read data valid, decoder captures it
// S_EX  | ALU evaluates; branch decision and target captured on exit
// S_MEM | data memory access; held while stall
// S_WB  | write back; PC advances on exit
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_take;
  logic [31:0] r_target;
  // One-hot strobes, bit order {IF, ID, EX, MEM, WB}
  logic [4:0]  r_phase;

  logic [31:0] w_pc_plus4;
  logic        w_take;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_take = 1'b0;
    case (bus.Pc_cmd)
      2'b10:   w_take = (bus.Pc_val == 2'b01) ? 1'b1 : bus.alu_cond;
      2'b11:   w_take = 1'b1;
      default: w_take = 1'b0;
    endcase
  end

  assign w_target = (bus.Pc_cmd == 2'b11) ? bus.rs1_data : (w_pc_plus4 + bus.Iv);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IF;
      r_phase  <= 5'b10000;
      r_pc     <= RESET_PC & ALIGN_MASK;
      r_take   <= 1'b0;
      r_target <= 32'd0;
    end else begin
      case (r_state)
        S_IF: begin
          if (bus.run) begin
            r_state <= S_ID;
            r_phase <= 5'b01000;
          end
        end
        S_ID: begin
          r_state <= S_EX;
          r_phase <= 5'b00100;
        end
        S_EX: begin
          r_state  <= S_MEM;
          r_phase  <= 5'b00010;
          r_take   <= w_take;
          r_target <= w_target;
        end
        S_MEM: begin
          if (!bus.stall) begin
            r_state <= S_WB;
            r_phase <= 5'b00001;
          end
        end
        S_WB: begin
          r_state <= S_IF;
          r_phase <= 5'b10000;
          r_pc    <= (r_take ? r_target : w_pc_plus4) & ALIGN_MASK;
          r_take  <= 1'b0;
        end
        default: begin
          r_state <= S_IF;
          r_phase <= 5'b10000;
        end
      endcase
    end
  end

  assign bus.i_address = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.IF        = r_phase[4];
  assign bus.ID        = r_phase[3];
  assign bus.EX        = r_phase[2];
  assign bus.MEM       = r_phase[1];
  assign bus.WB        = r_phase[0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table of decoder commands with a next-PC scoreboard.
module tb_pc_sequencer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [1:0]  val;
    logic [31:0] iv;
    logic [31:0] rs1;
    logic        cond;
    int          n_idle;
    int          n_stall;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] phase();
    return {27'd0, bus.IF, bus.ID, bus.EX, bus.MEM, bus.WB};
  endfunction

  task automatic drive_garbage();
    bus.Pc_cmd   = 2'b11;
    bus.Pc_val   = 2'b11;
    bus.Iv       = 32'h7777_0000;
    bus.rs1_data = 32'hDEAD_BEE0;
    bus.alu_cond = 1'b1;
  endtask

  // Entered and left at a falling edge with the DUT in IF.
  task automatic run_instr(input vec_t v);
    logic [31:0] pc;
    pc = cur_pc;
    chk("if_phase", phase(), 32'h10);
    chk("if_addr", bus.i_address, pc);
    chk("if_plus4", bus.pc_plus4, pc + 32'd4);
    bus.run = 1'b0;
    for (int k = 0; k < v.n_idle; k++) begin
      @(negedge clk);
      chk("idle_phase", phase(), 32'h10);
      chk("idle_addr", bus.i_address, pc);
    end
    bus.run = 1'b1;
    @(negedge clk);
    chk("id_phase", phase(), 32'h08);
    chk("id_addr", bus.i_address, pc);
    bus.run   = 1'b0;
    bus.stall = 1'b1;
    drive_garbage();
    @(negedge clk);
    chk("ex_phase", phase(), 32'h04);
    chk("ex_plus4", bus.pc_plus4, pc + 32'd4);
    bus.Pc_cmd   = v.cmd;
    bus.Pc_val   = v.val;
    bus.Iv       = v.iv;
    bus.rs1_data = v.rs1;
    bus.alu_cond = v.cond;
    bus.stall    = (v.n_stall > 0);
    exp_q.push_back(v.exp_next);
    @(negedge clk);
    chk("mem_phase", phase(), 32'h02);
    chk("mem_addr", bus.i_address, pc);
    drive_garbage();
    for (int k = 1; k <= v.n_stall; k++) begin
      @(negedge clk);
      chk("stall_phase", phase(), 32'h02);
      chk("stall_addr", bus.i_address, pc);
      bus.stall = (k < v.n_stall);
    end
    @(negedge clk);
    chk("wb_phase", phase(), 32'h01);
    chk("wb_addr", bus.i_address, pc);
    bus.stall = 1'b1;
    @(negedge clk);
    chk("next_phase", phase(), 32'h10);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      cur_pc = exp_q.pop_front();
      chk("next_addr", bus.i_address, cur_pc);
      chk("next_plus4", bus.pc_plus4, cur_pc + 32'd4);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{2'b00, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0104};
    vecs[1]  = '{2'b00, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 3, 32'h0000_0108};
    vecs[2]  = '{2'b10, 2'b01, 32'h0000_00F4, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0200};
    vecs[3]  = '{2'b10, 2'b00, 32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 0, 1, 32'h0000_01F4};
    vecs[4]  = '{2'b11, 2'b11, 32'h0000_0000, 32'h0000_0202, 1'b0, 1, 0, 32'h0000_0200};
    vecs[5]  = '{2'b10, 2'b00, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0204};
    vecs[6]  = '{2'b11, 2'b11, 32'h0000_0000, 32'h0000_0043, 1'b0, 0, 2, 32'h0000_0040};
    vecs[7]  = '{2'b11, 2'b11, 32'h0000_0000, 32'h0000_1003, 1'b0, 0, 0, 32'h0000_1000};
    vecs[8]  = '{2'b01, 2'b01, 32'h0000_0100, 32'h0000_0000, 1'b1, 0, 0, 32'h0000_1004};
    vecs[9]  = '{2'b10, 2'b10, 32'h0000_0008, 32'h0000_0000, 1'b1, 1, 0, 32'h0000_1010};
    vecs[10] = '{2'b10, 2'b11, 32'h0000_0020, 32'h0000_5000, 1'b0, 0, 0, 32'h0000_1014};
    vecs[11] = '{2'b11, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 32'hFFFF_FFFC};
    vecs[12] = '{2'b00, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0000};
    vecs[13] = '{2'b10, 2'b01, 32'h0000_0100, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0104};
    vecs[14] = '{2'b10, 2'b01, 32'h0000_0003, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0108};

    reset_n   = 1'b0;
    bus.run   = 1'b1;
    bus.stall = 1'b1;
    drive_garbage();
    @(negedge clk);
    @(negedge clk);
    chk("rst_phase", phase(), 32'h10);
    chk("rst_addr", bus.i_address, 32'h0000_0100);
    chk("rst_plus4", bus.pc_plus4, 32'h0000_0104);
    reset_n = 1'b1;
    cur_pc  = 32'h0000_0100;

    for (int i = 0; i < 15; i++) run_instr(vecs[i]);

    // Reset asserted mid-EX: immediate return to IF at RESET_PC, then a clean restart.
    bus.run = 1'b1;
    @(negedge clk);
    chk("pre_id", phase(), 32'h08);
    bus.run = 1'b0;
    @(negedge clk);
    chk("pre_ex", phase(), 32'h04);
    bus.Pc_cmd   = 2'b11;
    bus.rs1_data = 32'h0000_0500;
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_phase", phase(), 32'h10);
    chk("async_rst_addr", bus.i_address, 32'h0000_0100);
    chk("async_rst_plus4", bus.pc_plus4, 32'h0000_0104);
    bus.run = 1'b1;
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_id", phase(), 32'h08);
    chk("post_rst_addr", bus.i_address, 32'h0000_0100);
    bus.run = 1'b0;
    @(negedge clk);
    bus.Pc_cmd = 2'b00;
    bus.Pc_val = 2'b00;
    bus.stall  = 1'b0;
    @(negedge clk);
    drive_garbage();
    @(negedge clk);
    chk("post_rst_wb", phase(), 32'h01);
    @(negedge clk);
    chk("post_rst_next", bus.i_address, 32'h0000_0104);

    // Reset while MEM is held by stall: reset must win.
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    bus.Pc_cmd = 2'b00;
    bus.stall  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_hold", phase(), 32'h02);
    #1 reset_n = 1'b0;
    #1;
    chk("stall_rst_phase", phase(), 32'h10);
    chk("stall_rst_addr", bus.i_address, 32'h0000_0100);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("stall_rst_idle", phase(), 32'h10);
    cur_pc = 32'h0000_0100;
    run_instr(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
